// File: rtl/pio_pixel_loader.sv
// pio_pixel_loader: Nios II PIO pixel-load receiver; define PIO_LOADER_SYNC_EN to add a two-flop input synchroniser
module pio_pixel_loader #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 16,
  parameter int IMG_PIXELS = 65536
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [DATA_W-1:0] pio_data,
  input  logic              pio_write_en,
  input  logic              pio_start_bit,
  input  logic              pio_reset_cnt,
  input  logic              filter_busy,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              start_pulse,
  output logic              frame_full,
  output logic              overrun,
  output logic [ADDR_W:0]   byte_count
);
  localparam int PW = DATA_W + 3;
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(IMG_PIXELS);
  typedef enum logic [1:0] {LOAD, READY, RUN} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] pre, s1;
  logic w2, st2, w_ev, s_ev, rc_q, seen_q, seen_d, we_d, sp_d, full_d, ovr_d;
  logic [DATA_W-1:0] d_q;
  logic [ADDR_W:0] cnt_d;
`ifdef PIO_LOADER_SYNC_EN
  logic [PW-1:0] m1, m2;
  // two-flop synchroniser ahead of the sample stage
  always_ff @(posedge clk_clk) begin
    m1 <= reset_reset ? '0 : {pio_data, pio_write_en, pio_start_bit, pio_reset_cnt};
    m2 <= reset_reset ? '0 : m1;
  end
  assign pre = m2;
`else
  assign pre = {pio_data, pio_write_en, pio_start_bit, pio_reset_cnt};
`endif
  // sample, history and registered rising-edge events with data aligned to the write edge
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      s1   <= '0;
      w2   <= 1'b0;
      st2  <= 1'b0;
      w_ev <= 1'b0;
      s_ev <= 1'b0;
      rc_q <= 1'b0;
      d_q  <= '0;
    end else begin
      s1   <= pre;
      w2   <= s1[2];
      st2  <= s1[1];
      w_ev <= s1[2] & ~w2;
      s_ev <= s1[1] & ~st2;
      rc_q <= s1[0];
      d_q  <= s1[PW-1:3];
    end
  end
  // next state and next output values; reset_cnt overrides any edge seen in the same cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = byte_count;
    full_d  = frame_full;
    ovr_d   = overrun;
    seen_d  = seen_q;
    we_d    = 1'b0;
    sp_d    = 1'b0;
    if (rc_q) begin
      state_d = LOAD;
      cnt_d   = '0;
      full_d  = 1'b0;
      ovr_d   = 1'b0;
      seen_d  = 1'b0;
    end else begin
      case (state_q)
        LOAD: if (w_ev) begin
          we_d    = 1'b1;
          cnt_d   = byte_count + 1'b1;
          full_d  = cnt_d == FULL;
          state_d = cnt_d == FULL ? READY : LOAD;
        end
        READY: begin
          ovr_d   = overrun | w_ev;
          sp_d    = s_ev;
          seen_d  = 1'b0;
          state_d = s_ev ? RUN : READY;
        end
        RUN: begin
          ovr_d  = overrun | w_ev;
          seen_d = seen_q | filter_busy;
          if (seen_q && !filter_busy) begin
            state_d = LOAD;
            cnt_d   = '0;
            full_d  = 1'b0;
            seen_d  = 1'b0;
          end
        end
        default: state_d = LOAD;
      endcase
    end
  end
  // state and output registers; address and data only move on a store
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q     <= LOAD;
      byte_count  <= '0;
      frame_full  <= 1'b0;
      overrun     <= 1'b0;
      seen_q      <= 1'b0;
      mem_we      <= 1'b0;
      start_pulse <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      state_q     <= state_d;
      byte_count  <= cnt_d;
      frame_full  <= full_d;
      overrun     <= ovr_d;
      seen_q      <= seen_d;
      mem_we      <= we_d;
      start_pulse <= sp_d;
      mem_addr    <= we_d ? byte_count[ADDR_W-1:0] : mem_addr;
      mem_wdata   <= we_d ? d_q : mem_wdata;
    end
  end
endmodule
